// File: rtl/muldiv_iter_unit_if.sv
// EX-stage Start/Busy handshake and HI/LO read-back for the iterative mul/div unit.
interface muldiv_iter_unit_if #(parameter int W = 32);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         flush;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (output start, op, d1, d2, flush, input busy, hi, lo);
    modport slave  (input start, op, d1, d2, flush, output busy, hi, lo);
endinterface

// File: rtl/muldiv_iter_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO: magnitude datapath for ITER
// cycles, then one sign-fixup cycle that commits the result.
module muldiv_iter_unit #(
    parameter int ITER = 32,
    parameter int W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    muldiv_iter_unit_if.slave bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t         r_state;
    logic           r_busy;
    logic [CW-1:0]  r_cnt;
    logic           r_is_div;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_dz;
    logic [W-1:0]   r_opnd;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic           w_req, w_arith, w_signed, w_is_div, w_s1, w_s2;
    logic [W-1:0]   w_a1, w_a2;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_mul_nxt, w_div_nxt, w_prod;
    logic [W:0]     w_rem_sh;
    logic           w_ge;
    logic [W-1:0]   w_rem_sub, w_quo, w_rem;

    assign w_req    = bus.start & (r_state == S_IDLE) & ~bus.flush;
    assign w_arith  = w_req & (bus.op <= 3'd3);
    assign w_signed = ~bus.op[0];
    assign w_is_div = bus.op[1];
    assign w_s1     = w_signed & bus.d1[W-1];
    assign w_s2     = w_signed & bus.d2[W-1];
    assign w_a1     = w_s1 ? -bus.d1 : bus.d1;
    assign w_a2     = w_s2 ? -bus.d2 : bus.d2;

    // Multiply: acc = {partial product, remaining multiplier bits}; carry rides into the shift.
    assign w_sum     = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opnd};
    assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; W+1-bit shifted remainder keeps
    // divisors with the MSB set correct.
    assign w_rem_sh  = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_sub = w_rem_sh[W-1:0] - r_opnd;
    assign w_div_nxt = {(w_ge ? w_rem_sub : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arith) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_s1 ^ w_s2;
                        r_neg_r  <= w_s1;
                        r_dz     <= (bus.d2 == '0);
                        r_opnd   <= w_is_div ? w_a2 : w_a1;
                        r_acc    <= {{W{1'b0}}, (w_is_div ? w_a1 : w_a2)};
                    end else if (w_req && bus.op == 3'd4) begin
                        r_hi <= bus.d1;
                    end else if (w_req && bus.op == 3'd5) begin
                        r_lo <= bus.d1;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(ITER - 1)) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.flush) begin
                        if (!r_is_div) begin
                            {r_hi, r_lo} <= w_prod;
                        end else if (!r_dz) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit: arithmetic reference model checked every cycle,
// plus literal HI/LO/busy expectations from hand-computed vectors.
module tb_muldiv_iter_unit;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    muldiv_iter_unit_if #(.W(32)) bus ();

    muldiv_iter_unit #(.ITER(32), .W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: {hi, lo} straight from 64-bit integer arithmetic.
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        case (op)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                res = {sr[31:0], sq[31:0]};
            end
            3'd3: if (b != 0) begin
                uq = ua / ub;
                ur = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Model: a pending result plus a countdown of remaining busy cycles.
    int          m_left;
    logic        m_wr;
    logic [63:0] m_res;
    logic [31:0] m_hi, m_lo;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_wr   <= 1'b0;
            m_res  <= '0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left != 0) begin
            if (bus.flush) m_left <= 0;
            else if (m_left == 1) begin
                m_left <= 0;
                if (m_wr) {m_hi, m_lo} <= m_res;
            end else m_left <= m_left - 1;
        end else if (bus.start && !bus.flush) begin
            if (bus.op <= 3'd3) begin
                m_left <= 33;
                m_res  <= calc(bus.op, bus.d1, bus.d2);
                m_wr   <= !(bus.op[1] && bus.d2 == 0);
            end else if (bus.op == 3'd4) m_hi <= bus.d1;
            else if (bus.op == 3'd5) m_lo <= bus.d1;
        end
    end

    always @(posedge clk) begin
        #1;
        check("model_busy", {31'b0, bus.busy}, {31'b0, (m_left != 0)});
        check("model_hi", bus.hi, m_hi);
        check("model_lo", bus.lo, m_lo);
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.d1    = a;
        bus.d2    = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 100) check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        issue(op, a, b);
        wait_idle(cyc);
        check({name, "_busy_cycles"}, cyc, 32'd33);
        check({name, "_hi"}, bus.hi, ehi);
        check({name, "_lo"}, bus.lo, elo);
    endtask

    initial begin
        int cyc;
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.d1    = '0;
        bus.d2    = '0;
        bus.flush = 1'b0;
        #12;
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_neg2x3", 3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_7xneg3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_neg2", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_bigdvsr", 3'd3, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1);
        run_op("div_by_zero", 3'd2, 32'd55, 32'd0, 32'h7FFFFFFE, 32'd1);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

        issue(3'd5, 32'h12345678, 32'd0);
        check("mtlo_busy", {31'b0, bus.busy}, 32'd0);
        check("mtlo_lo", bus.lo, 32'h12345678);
        issue(3'd4, 32'hCAFEF00D, 32'd0);
        check("mthi_busy", {31'b0, bus.busy}, 32'd0);
        check("mthi_hi", bus.hi, 32'hCAFEF00D);

        // Flush at the 10th cycle of a DIVU.
        issue(3'd3, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        check("flush_hi", bus.hi, 32'hCAFEF00D);
        check("flush_lo", bus.lo, 32'h12345678);

        // MTHI with flush in the same cycle is dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.d1 = 32'h0BADBEEF; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_mthi_hi", bus.hi, 32'hCAFEF00D);

        issue(3'd6, 32'h11111111, 32'd2);
        check("noop_busy", {31'b0, bus.busy}, 32'd0);
        check("noop_lo", bus.lo, 32'h12345678);

        // A second start while busy is ignored.
        issue(3'd3, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(3'd1, 32'd3, 32'd5);
        wait_idle(cyc);
        check("restart_cycles", cyc, 32'd27);
        check("restart_hi", bus.hi, 32'd2);
        check("restart_lo", bus.lo, 32'd14);

        // Asynchronous reset mid-MULT.
        issue(3'd0, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_busy", {31'b0, bus.busy}, 32'd0);
        check("areset_hi", bus.hi, 32'd0);
        check("areset_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("post_reset_multu", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
